fd_circle_fetch: RTL and testbench

Sequential FAST-style circle fetcher for the feature-detection path. On each `start` it takes a reference pixel coordinate, issues 17 single-cycle SRAM reads: the centre pixel, then the 16 Bresenham radius-3 circle points in fixed clockwise order. It collects the returned pixels into a packed output vector for the downstream corner-score logic. It generalises the earlier combinational address calculator to parametrised image geometry, pixel width and SRAM latency, and adds its own sequencing and optional border rejection.

---
 rtl/fd_circle_fetch_pkg.sv | 22 ++
 rtl/fd_circle_fetch_if.sv | 33 +++
 rtl/fd_circle_fetch_addr_gen.sv | 35 +++
 rtl/fd_circle_fetch.sv | 157 +++++++++++++++
 tb/tb_fd_circle_fetch.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/fd_circle_fetch_pkg.sv
// Shared constants, circle offset tables and types for the FAST circle fetcher.
package fd_pkg;

    localparam int NUM_PTS = 16;
    localparam int RADIUS  = 3;
    localparam int NUM_RD  = NUM_PTS + 1;
    localparam int IDX_W   = 5;

    // Index 0 is the centre; 1..16 walk the radius-3 Bresenham circle clockwise from the top.
    localparam int signed DX [NUM_RD] = '{0,  0,  1,  2,  3, 3, 3, 2, 1, 0, -1, -2, -3, -3, -3, -2, -1};
    localparam int signed DY [NUM_RD] = '{0, -3, -3, -2, -1, 0, 1, 2, 3, 3,  3,  2,  1,  0, -1, -2, -3};

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PTS);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_e;

    typedef struct packed {
        logic             valid;
        logic [IDX_W-1:0] idx;
    } tag_t;

endpackage

// File: rtl/fd_circle_fetch_if.sv
// Request/response and SRAM read port bundle of the circle fetcher.
interface fd_circle_fetch_if #(
    parameter int COLUMNS = 180,
    parameter int ROWS    = 120,
    parameter int ADDR_W  = 15,
    parameter int PIX_W   = 8
);
    localparam int XW = $clog2(COLUMNS);
    localparam int YW = $clog2(ROWS);

    logic                  start;
    logic [XW-1:0]         ref_x;
    logic [YW-1:0]         ref_y;
    logic                  busy;
    logic [ADDR_W-1:0]     sram_addr;
    logic                  sram_read;
    logic [PIX_W-1:0]      sram_rdata;
    logic                  done;
    logic                  border;
    logic [PIX_W-1:0]      center_pix;
    logic [16*PIX_W-1:0]   circle_pix;

    modport master (
        output start, ref_x, ref_y, sram_rdata,
        input  busy, sram_addr, sram_read, done, border, center_pix, circle_pix
    );

    modport slave (
        input  start, ref_x, ref_y, sram_rdata,
        output busy, sram_addr, sram_read, done, border, center_pix, circle_pix
    );

endinterface

// File: rtl/fd_circle_fetch_addr_gen.sv
// Combinational SRAM address of circle point idx around (ref_x, ref_y).
module fd_addr_gen
    import fd_pkg::*;
#(
    parameter int COLUMNS   = 180,
    parameter int ADDR_W    = 15,
    parameter int BASE_ADDR = 0,
    parameter int XW        = 8,
    parameter int YW        = 7
) (
    input  logic [XW-1:0]     ref_x_i,
    input  logic [YW-1:0]     ref_y_i,
    input  logic [IDX_W-1:0]  idx_i,
    output logic [ADDR_W-1:0] addr_o
);

    int dx;
    int dy;
    int lin;

    always_comb begin
        dx = 0;
        dy = 0;
        for (int unsigned k = 0; k < NUM_RD; k++) begin
            if (idx_i == IDX_W'(k)) begin
                dx = DX[k];
                dy = DY[k];
            end
        end
        // Out-of-image points are allowed to wrap; truncation gives the raw address.
        lin    = BASE_ADDR + (int'(ref_y_i) + dy) * COLUMNS + int'(ref_x_i) + dx;
        addr_o = ADDR_W'(lin);
    end

endmodule

// File: rtl/fd_circle_fetch.sv
// Sequential FAST circle fetcher: 17 SRAM reads per start, packed pixel outputs.
// Optional border rejection is enabled by defining FD_BORDER_CHECK_EN.
module fd_circle_fetch
    import fd_pkg::*;
#(
    parameter int COLUMNS   = 180,
    parameter int ROWS      = 120,
    parameter int ADDR_W    = 15,
    parameter int PIX_W     = 8,
    parameter int SRAM_LAT  = 1,
    parameter int BASE_ADDR = 0
) (
    input  logic          clk,
    input  logic          rst,
    fd_circle_fetch_if.slave bus
);

    localparam int XW = $clog2(COLUMNS);
    localparam int YW = $clog2(ROWS);

    state_e              state_q;
    logic [IDX_W-1:0]    idx_q;
    logic [XW-1:0]       refx_q;
    logic [YW-1:0]       refy_q;
    logic                busy_q;
    logic                read_q;
    logic                done_q;
    logic                border_q;
    logic [ADDR_W-1:0]   addr_q;
    tag_t                tag_q [SRAM_LAT];
    logic [PIX_W-1:0]    pix_q [NUM_RD];

    logic [XW-1:0]       gen_x;
    logic [YW-1:0]       gen_y;
    logic [IDX_W-1:0]    gen_idx;
    logic [ADDR_W-1:0]   addr_d;
    logic                reject;

    // In IDLE the generator looks at the live request so read 0 can issue in the next cycle.
    always_comb begin
        gen_x   = refx_q;
        gen_y   = refy_q;
        gen_idx = idx_q + 1'b1;
        if (state_q == IDLE) begin
            gen_x   = bus.ref_x;
            gen_y   = bus.ref_y;
            gen_idx = '0;
        end
    end

    fd_addr_gen #(
        .COLUMNS   (COLUMNS),
        .ADDR_W    (ADDR_W),
        .BASE_ADDR (BASE_ADDR),
        .XW        (XW),
        .YW        (YW)
    ) u_addr_gen (
        .ref_x_i (gen_x),
        .ref_y_i (gen_y),
        .idx_i   (gen_idx),
        .addr_o  (addr_d)
    );

`ifdef FD_BORDER_CHECK_EN
    localparam logic [XW-1:0] X_LO = XW'(RADIUS);
    localparam logic [XW-1:0] X_HI = XW'(COLUMNS - 1 - RADIUS);
    localparam logic [YW-1:0] Y_LO = YW'(RADIUS);
    localparam logic [YW-1:0] Y_HI = YW'(ROWS - 1 - RADIUS);

    assign reject = (bus.ref_x < X_LO) || (bus.ref_x > X_HI) ||
                    (bus.ref_y < Y_LO) || (bus.ref_y > Y_HI);
`else
    assign reject = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            refx_q   <= '0;
            refy_q   <= '0;
            busy_q   <= 1'b0;
            read_q   <= 1'b0;
            done_q   <= 1'b0;
            border_q <= 1'b0;
            addr_q   <= '0;
            for (int unsigned i = 0; i < SRAM_LAT; i++) tag_q[i] <= '0;
            for (int unsigned k = 0; k < NUM_RD; k++) pix_q[k] <= '0;
        end else begin
            done_q   <= 1'b0;
            tag_q[0] <= tag_t'{valid: read_q, idx: idx_q};
            for (int unsigned i = 1; i < SRAM_LAT; i++) tag_q[i] <= tag_q[i-1];

            if (tag_q[SRAM_LAT-1].valid) begin
                for (int unsigned k = 0; k < NUM_RD; k++) begin
                    if (tag_q[SRAM_LAT-1].idx == IDX_W'(k)) pix_q[k] <= bus.sram_rdata;
                end
            end

            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        if (reject) begin
                            border_q <= 1'b1;
                            done_q   <= 1'b1;
                            state_q  <= DONE;
                        end else begin
                            border_q <= 1'b0;
                            refx_q   <= bus.ref_x;
                            refy_q   <= bus.ref_y;
                            idx_q    <= '0;
                            addr_q   <= addr_d;
                            read_q   <= 1'b1;
                            busy_q   <= 1'b1;
                            state_q  <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    if (idx_q == LAST_IDX) begin
                        read_q  <= 1'b0;
                        state_q <= DRAIN;
                    end else begin
                        idx_q  <= idx_q + 1'b1;
                        addr_q <= addr_d;
                    end
                end
                DRAIN: begin
                    // Leave as the final read's data lands, so done follows its capture directly.
                    if (tag_q[SRAM_LAT-1].valid && tag_q[SRAM_LAT-1].idx == LAST_IDX) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy       = busy_q;
    assign bus.sram_read  = read_q;
    assign bus.sram_addr  = addr_q;
    assign bus.done       = done_q;
    assign bus.border     = border_q;
    assign bus.center_pix = pix_q[0];

    for (genvar k = 1; k <= NUM_PTS; k++) begin : g_circle
        assign bus.circle_pix[k*PIX_W-1 -: PIX_W] = pix_q[k];
    end

endmodule

// File: tb/tb_fd_circle_fetch.sv
// Directed bench for fd_circle_fetch: SRAM_LAT=1 and SRAM_LAT=3 instances run side by side.
module tb_fd_circle_fetch;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fd_circle_fetch_if #(.COLUMNS(180), .ROWS(120), .ADDR_W(15), .PIX_W(8)) b1 ();
    fd_circle_fetch_if #(.COLUMNS(180), .ROWS(120), .ADDR_W(15), .PIX_W(8)) b3 ();

    fd_circle_fetch #(.COLUMNS(180), .ROWS(120), .ADDR_W(15), .PIX_W(8), .SRAM_LAT(1), .BASE_ADDR(0))
        u_dut1 (.clk(clk), .rst(rst), .bus(b1));
    fd_circle_fetch #(.COLUMNS(180), .ROWS(120), .ADDR_W(15), .PIX_W(8), .SRAM_LAT(3), .BASE_ADDR(0))
        u_dut3 (.clk(clk), .rst(rst), .bus(b3));

    // SRAM models returning addr[7:0] after the configured latency
    logic [7:0] p1;
    logic [7:0] p3 [3];
    always @(posedge clk) begin
        p1    <= b1.sram_read ? b1.sram_addr[7:0] : 8'h00;
        p3[0] <= b3.sram_read ? b3.sram_addr[7:0] : 8'h00;
        p3[1] <= p3[0];
        p3[2] <= p3[1];
    end
    assign b1.sram_rdata = p1;
    assign b3.sram_rdata = p3[2];

`ifdef FD_BORDER_CHECK_EN
    localparam bit BC = 1'b1;
`else
    localparam bit BC = 1'b0;
`endif

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h required %0h", nm, act, exp);
    endtask

    int mdx [17] = '{0,  0,  1,  2,  3, 3, 3, 2, 1, 0, -1, -2, -3, -3, -3, -2, -1};
    int mdy [17] = '{0, -3, -3, -2, -1, 0, 1, 2, 3, 3,  3,  2,  1,  0, -1, -2, -3};

    function automatic int maddr(input int x, input int y, input int k);
        return ((y + mdy[k]) * 180 + x + mdx[k]) & 32'h7fff;
    endfunction

    function automatic logic [127:0] mcircle(input int x, input int y);
        logic [127:0] v;
        int a;
        v = '0;
        for (int k = 1; k <= 16; k++) begin
            a = maddr(x, y, k);
            v[(k-1)*8 +: 8] = 8'(a);
        end
        return v;
    endfunction

    // Results of one run_fetch
    int d1, d3, n1, n3;
    logic bd1, bz1;
    int rd1 [32];
    int rd3 [32];

    task automatic run_fetch(input int x, input int y, input bit poke);
        d1 = -1; d3 = -1; n1 = 0; n3 = 0; bd1 = 1'bx; bz1 = 1'bx;
        for (int i = 0; i < 32; i++) begin rd1[i] = -1; rd3[i] = -1; end
        @(posedge clk); #1;
        b1.start = 1'b1; b1.ref_x = 8'(x); b1.ref_y = 7'(y);
        b3.start = 1'b1; b3.ref_x = 8'(x); b3.ref_y = 7'(y);
        @(posedge clk); #1;
        for (int cyc = 1; cyc < 60 && (d1 < 0 || d3 < 0); cyc++) begin
            if (poke && cyc == 5) begin
                b1.start = 1'b1; b1.ref_x = 8'd20; b1.ref_y = 7'd20;
                b3.start = 1'b1; b3.ref_x = 8'd20; b3.ref_y = 7'd20;
            end else begin
                b1.start = 1'b0;
                b3.start = 1'b0;
            end
            @(negedge clk);
            if (b1.sram_read) begin if (n1 < 32) rd1[n1] = int'(b1.sram_addr); n1++; end
            if (b3.sram_read) begin if (n3 < 32) rd3[n3] = int'(b3.sram_addr); n3++; end
            if (b1.done && d1 < 0) begin d1 = cyc; bd1 = b1.border; bz1 = b1.busy; end
            if (b3.done && d3 < 0) d3 = cyc;
            @(posedge clk); #1;
        end
        b1.start = 1'b0;
        b3.start = 1'b0;
    endtask

    typedef struct {
        int x; int y; bit rej;
        int a0; int a1; int a5; int a16; int center;
    } vec_t;

    vec_t vec [6];
    logic [7:0]   exp_center;
    logic [127:0] exp_circle;

    initial begin
        int bad1, bad3, quiet, late_done;

        vec[0] = '{10, 10, 1'b0, 1810, 1270, 1813, 1269, 8'h12};
        vec[1] = '{3, 3, 1'b0, 543, 3, 546, 2, 31};
        vec[2] = '{176, 116, 1'b0, 21056, 20516, 21059, 20515, 64};
        vec[3] = '{2, 50, BC, 9002, 8462, 9005, 8461, 42};
        vec[4] = '{177, 50, BC, 9177, 8637, 9180, 8636, 217};
        vec[5] = '{10, 10, 1'b0, 1810, 1270, 1813, 1269, 8'h12};

        b1.start = 1'b0; b1.ref_x = '0; b1.ref_y = '0;
        b3.start = 1'b0; b3.ref_x = '0; b3.ref_y = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset busy", b1.busy, 0);
        chk("reset sram_read", b1.sram_read, 0);
        chk("reset done", b1.done, 0);
        chk("reset border", b1.border, 0);
        chk("reset sram_addr", b1.sram_addr, 0);
        chk("reset center", b1.center_pix, 0);
        chk("reset circle", b1.circle_pix, 0);
        chk("reset busy lat3", b3.busy, 0);
        rst = 1'b0;
        exp_center = '0;
        exp_circle = '0;

        for (int v = 0; v < 6; v++) begin
            run_fetch(vec[v].x, vec[v].y, 1'b0);
            if (vec[v].rej) begin
                chk("reject done cycle", d1, 1);
                chk("reject done cycle lat3", d3, 1);
                chk("reject read count", n1, 0);
                chk("reject border", bd1, 1);
            end else begin
                exp_center = 8'(vec[v].center);
                exp_circle = mcircle(vec[v].x, vec[v].y);
                chk("done cycle", d1, 19);
                chk("done cycle lat3", d3, 21);
                chk("read count", n1, 17);
                chk("read count lat3", n3, 17);
                chk("addr idx0", rd1[0], vec[v].a0);
                chk("addr idx1", rd1[1], vec[v].a1);
                chk("addr idx5", rd1[5], vec[v].a5);
                chk("addr idx16", rd1[16], vec[v].a16);
                bad1 = 0; bad3 = 0;
                for (int k = 0; k < 17; k++) begin
                    if (rd1[k] != maddr(vec[v].x, vec[v].y, k)) bad1++;
                    if (rd3[k] != maddr(vec[v].x, vec[v].y, k)) bad3++;
                end
                chk("addr sequence", bad1, 0);
                chk("addr sequence lat3", bad3, 0);
                chk("border at done", bd1, 0);
            end
            chk("busy at done", bz1, 0);
            chk("center", b1.center_pix, exp_center);
            chk("circle", b1.circle_pix, exp_circle);
            chk("center lat3", b3.center_pix, exp_center);
            chk("circle lat3", b3.circle_pix, exp_circle);
            @(negedge clk);
            chk("border held", b1.border, vec[v].rej);
            chk("idle busy", b1.busy, 0);
        end

        // Second start while busy must be dropped
        run_fetch(10, 10, 1'b1);
        chk("poke done cycle", d1, 19);
        chk("poke read count", n1, 17);
        chk("poke center", b1.center_pix, 8'h12);
        chk("poke circle", b1.circle_pix, mcircle(10, 10));
        chk("poke circle lat3", b3.circle_pix, mcircle(10, 10));
        quiet = 0;
        repeat (4) begin
            @(negedge clk);
            if (b1.busy || b1.sram_read || b3.busy || b3.sram_read) quiet++;
        end
        chk("poke no restart", quiet, 0);

        // Reset in cycle 8 of a fetch
        @(posedge clk); #1;
        b1.start = 1'b1; b1.ref_x = 8'd10; b1.ref_y = 7'd10;
        b3.start = 1'b1; b3.ref_x = 8'd10; b3.ref_y = 7'd10;
        @(posedge clk); #1;
        b1.start = 1'b0; b3.start = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        chk("pre-reset busy", b1.busy, 1);
        chk("pre-reset sram_read", b1.sram_read, 1);
        rst = 1'b1;
        #1;
        chk("abort sram_read", b1.sram_read, 0);
        chk("abort busy", b1.busy, 0);
        chk("abort center", b1.center_pix, 0);
        chk("abort circle", b1.circle_pix, 0);
        chk("abort busy lat3", b3.busy, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        late_done = 0;
        repeat (40) begin
            @(negedge clk);
            if (b1.done || b3.done || b1.sram_read || b3.sram_read) late_done++;
        end
        chk("abort no done", late_done, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
